// File: rtl/seg7_scan_driver.sv
// Snapshots four hex digits on LOAD and scans them onto a common-anode 4-digit 7-segment display.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 3..1.
module seg7_scan_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter int REFRESH_WIDTH = 17
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD,
  input  logic [15:0] DIGITS_IN,
  input  logic [3:0]  DP_IN,
  input  logic        BLANK,
  output logic [6:0]  SEG_OUT,
  output logic        DP_OUT,
  output logic [3:0]  AN_OUT,
  output logic [1:0]  DIGIT_SEL,
  output logic        SCAN_TICK
);

  localparam logic [REFRESH_WIDTH-1:0] CNT_MAX = REFRESH_WIDTH'(REFRESH_DIV - 1);

  logic [REFRESH_WIDTH-1:0] refresh_cnt;
  logic [15:0]              shadow_digits;
  logic [3:0]               shadow_dp;
  logic [3:0]               cur_digit;
  logic                     cur_dp;
  logic                     lz_blank;
  logic [6:0]               cur_seg;

  always_comb begin
    cur_digit = shadow_digits[3:0];
    cur_dp    = shadow_dp[0];
    lz_blank  = 1'b0;
    case (DIGIT_SEL)
      2'd0: begin
        cur_digit = shadow_digits[3:0];
        cur_dp    = shadow_dp[0];
      end
      2'd1: begin
        cur_digit = shadow_digits[7:4];
        cur_dp    = shadow_dp[1];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz_blank  = (shadow_digits[15:4] == 12'd0);
`endif
      end
      2'd2: begin
        cur_digit = shadow_digits[11:8];
        cur_dp    = shadow_dp[2];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz_blank  = (shadow_digits[15:8] == 8'd0);
`endif
      end
      default: begin
        cur_digit = shadow_digits[15:12];
        cur_dp    = shadow_dp[3];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz_blank  = (shadow_digits[15:12] == 4'd0);
`endif
      end
    endcase
  end

  // Active-low segment patterns, bit order g..a
  always_comb begin
    cur_seg = 7'b1111111;
    case (cur_digit)
      4'h0: cur_seg = 7'b1000000;
      4'h1: cur_seg = 7'b1111001;
      4'h2: cur_seg = 7'b0100100;
      4'h3: cur_seg = 7'b0110000;
      4'h4: cur_seg = 7'b0011001;
      4'h5: cur_seg = 7'b0010010;
      4'h6: cur_seg = 7'b0000010;
      4'h7: cur_seg = 7'b1111000;
      4'h8: cur_seg = 7'b0000000;
      4'h9: cur_seg = 7'b0010000;
      4'hA: cur_seg = 7'b0001000;
      4'hB: cur_seg = 7'b0000011;
      4'hC: cur_seg = 7'b1000110;
      4'hD: cur_seg = 7'b0100001;
      4'hE: cur_seg = 7'b0000110;
      default: cur_seg = 7'b0001110;
    endcase
  end

  // LOAD is a fire-and-forget strobe with no ready: any edge with LOAD high captures
  // DIGITS_IN/DP_IN into the shadow; the display only ever reads the shadow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      refresh_cnt   <= '0;
      DIGIT_SEL     <= 2'd0;
      SCAN_TICK     <= 1'b0;
      shadow_digits <= 16'd0;
      shadow_dp     <= 4'd0;
      AN_OUT        <= 4'b1111;
      SEG_OUT       <= 7'b1111111;
      DP_OUT        <= 1'b1;
    end else begin
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        DIGIT_SEL   <= DIGIT_SEL + 2'd1;
        SCAN_TICK   <= 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
        SCAN_TICK   <= 1'b0;
      end
      if (LOAD) begin
        shadow_digits <= DIGITS_IN;
        shadow_dp     <= DP_IN;
      end
      if (BLANK || lz_blank) begin
        AN_OUT  <= 4'b1111;
        SEG_OUT <= 7'b1111111;
        DP_OUT  <= 1'b1;
      end else begin
        AN_OUT  <= ~(4'b0001 << DIGIT_SEL);
        SEG_OUT <= cur_seg;
        DP_OUT  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (REFRESH_DIV=4): reference model pushes expected outputs per cycle.
// Honours SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] DIGITS_IN = 16'd0;
  logic [3:0]  DP_IN = 4'd0;
  logic        BLANK = 1'b0;
  logic [6:0]  SEG_OUT;
  logic        DP_OUT;
  logic [3:0]  AN_OUT;
  logic [1:0]  DIGIT_SEL;
  logic        SCAN_TICK;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .REFRESH_WIDTH(2)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .DIGITS_IN(DIGITS_IN), .DP_IN(DP_IN),
    .BLANK(BLANK), .SEG_OUT(SEG_OUT), .DP_OUT(DP_OUT), .AN_OUT(AN_OUT),
    .DIGIT_SEL(DIGIT_SEL), .SCAN_TICK(SCAN_TICK)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  logic [6:0] dec_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          m_cnt;
  logic [1:0]  m_sel;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic lz(input logic [1:0] s, input logic [15:0] sh);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (s)
      2'd3: return sh[15:12] == 4'd0;
      2'd2: return sh[15:8] == 8'd0;
      2'd1: return sh[15:4] == 12'd0;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // driver: predict this edge's outputs from model state, advance model, then compare
  task automatic step();
    logic [14:0] e;
    logic [3:0]  an, d;
    logic [6:0]  seg;
    logic        dp, tk;
    logic [1:0]  nsel;
    if (RESET) begin
      e = {4'b1111, 7'b1111111, 1'b1, 2'd0, 1'b0};
      m_cnt = 0; m_sel = 2'd0; m_sh = 16'd0; m_dp = 4'd0;
    end else begin
      d  = m_sh[int'(m_sel)*4 +: 4];
      tk = (m_cnt == DIV - 1);
      nsel = tk ? m_sel + 2'd1 : m_sel;
      if (BLANK || lz(m_sel, m_sh)) begin
        an = 4'b1111; seg = 7'b1111111; dp = 1'b1;
      end else begin
        an = ~(4'b0001 << m_sel); seg = dec_tbl[d]; dp = ~m_dp[m_sel];
      end
      e = {an, seg, dp, nsel, tk};
      m_cnt = tk ? 0 : m_cnt + 1;
      m_sel = nsel;
      if (LOAD) begin m_sh = DIGITS_IN; m_dp = DP_IN; end
    end
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    check("out", {17'd0, AN_OUT, SEG_OUT, DP_OUT, DIGIT_SEL, SCAN_TICK}, {17'd0, exp_q.pop_front()});
  endtask

  int ticks;
  int seen2;
  int guard;

  initial begin
    // reset and free-running scan
    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    step();
    check("rst_an", {28'd0, AN_OUT}, 32'h0000_000E);
    check("rst_seg", {25'd0, SEG_OUT}, 32'h0000_0040);
    check("rst_dp", {31'd0, DP_OUT}, 32'd1);
    ticks = 0;
    repeat (16) begin step(); if (SCAN_TICK) ticks++; end
    check("tick_cnt", ticks, 4);

    // snapshot 4A07, then change inputs with LOAD low
    LOAD = 1'b1; DIGITS_IN = 16'h4A07; DP_IN = 4'b0100;
    step();
    LOAD = 1'b0; DIGITS_IN = 16'hFFFF; DP_IN = 4'b1111;
    seen2 = 0;
    repeat (16) begin
      step();
      if (AN_OUT == 4'b1011) begin
        seen2++;
        check("d2_seg", {25'd0, SEG_OUT}, {25'd0, 7'b0001000});
        check("d2_dp", {31'd0, DP_OUT}, 32'd0);
      end
      if (AN_OUT == 4'b0111) check("d3_seg", {25'd0, SEG_OUT}, {25'd0, 7'b0011001});
      if (AN_OUT == 4'b1110) check("d0_seg", {25'd0, SEG_OUT}, {25'd0, 7'b1111000});
    end
    check("d2_seen", {31'd0, seen2 > 0}, 32'd1);

    // LOAD coinciding with the 0->1 advance
    guard = 0;
    while (!(m_cnt == DIV - 1 && m_sel == 2'd0) && guard < 40) begin step(); guard++; end
    check("align3", {31'd0, guard < 40}, 32'd1);
    LOAD = 1'b1; DIGITS_IN = 16'h0090; DP_IN = 4'b0000;
    step();
    LOAD = 1'b0;
    step();
    check("t3_an", {28'd0, AN_OUT}, 32'h0000_000D);
    check("t3_seg", {25'd0, SEG_OUT}, {25'd0, 7'b0010000});

    // blanking keeps scan running
    BLANK = 1'b1; ticks = 0;
    repeat (10) begin
      step();
      if (SCAN_TICK) ticks++;
      check("blk_an", {28'd0, AN_OUT}, 32'h0000_000F);
    end
    check("blk_ticks", {31'd0, ticks >= 2 && ticks <= 3}, 32'd1);
    BLANK = 1'b0;
    repeat (8) step();

    // random traffic
    repeat (80) begin
      LOAD = ($urandom_range(0, 5) == 0);
      BLANK = ($urandom_range(0, 7) == 0);
      DIGITS_IN = 16'($urandom_range(0, 65535));
      DP_IN = 4'($urandom_range(0, 15));
      step();
    end
    LOAD = 1'b0; BLANK = 1'b0;

    // reset mid-slot on digit 2
    guard = 0;
    while (!(m_sel == 2'd2 && m_cnt == 1) && guard < 40) begin step(); guard++; end
    check("align5", {31'd0, guard < 40}, 32'd1);
    RESET = 1'b1;
    step();
    check("t5_sel", {30'd0, DIGIT_SEL}, 32'd0);
    check("t5_an", {28'd0, AN_OUT}, 32'h0000_000F);
    RESET = 1'b0;
    step();
    check("t5_seg", {25'd0, SEG_OUT}, {25'd0, 7'b1000000});

    // leading-zero behaviour with shadow 0050
    LOAD = 1'b1; DIGITS_IN = 16'h0050; DP_IN = 4'b1100;
    step();
    LOAD = 1'b0;
    repeat (16) begin
      step();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check("lz_an32", {30'd0, AN_OUT[3:2]}, 32'd3);
`else
      if (AN_OUT == 4'b1011 || AN_OUT == 4'b0111)
        check("nolz_seg", {25'd0, SEG_OUT}, {25'd0, 7'b1000000});
`endif
      if (AN_OUT == 4'b1101) check("t6_d1", {25'd0, SEG_OUT}, {25'd0, 7'b0010010});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
